// File: rtl/fifo_rd_stream.sv
// Read-side drainer for the async FIFO: pops with one-cycle read latency
// into a 3-entry skid buffer and presents words on a valid/ready stream.
module fifo_rd_stream #(
  parameter int D_SIZE = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              r_rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_rd_empty,
  input  logic [D_SIZE-1:0] fifo_d_output,
  output logic              fifo_rd_inc,
  output logic              m_valid,
  output logic [D_SIZE-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  drop_count
);

  logic [1:0]        occ_q, occ_d;
  logic              pend_q;
  logic [D_SIZE-1:0] buf_q [3];
  logic [D_SIZE-1:0] buf_d [3];
  logic [CNT_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [2:0]        used;
  logic [1:0]        wr_idx;
  logic              deq;
  logic              cap;

  // Counting in-flight pops reserves a slot for every word still en route
  assign used        = {1'b0, occ_q} + {2'b00, pend_q};
  assign fifo_rd_inc = en & ~flush & ~fifo_rd_empty & (used <= 3'd2);

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf_q[0];
  assign rd_count   = rd_q;
  assign drop_count = drop_q;

  assign deq    = m_valid & m_ready & ~flush;
  assign cap    = pend_q & ~flush;
  assign wr_idx = occ_q - {1'b0, deq};

  always_comb begin
    buf_d  = buf_q;
    occ_d  = occ_q;
    rd_d   = rd_q;
    drop_d = drop_q;
    if (flush) begin
      occ_d  = 2'd0;
      drop_d = drop_q + CNT_W'(used);
    end else begin
      if (deq) begin
        buf_d[0] = buf_q[1];
        buf_d[1] = buf_q[2];
      end
      if (cap) begin
        buf_d[wr_idx] = fifo_d_output;
      end
      occ_d = occ_q + {1'b0, cap} - {1'b0, deq};
      rd_d  = rd_q + CNT_W'(deq);
    end
  end

  always_ff @(posedge rd_clk or negedge r_rst) begin
    if (!r_rst) begin
      occ_q  <= 2'd0;
      pend_q <= 1'b0;
      rd_q   <= '0;
      drop_q <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      pend_q <= fifo_rd_inc;
      rd_q   <= rd_d;
      drop_q <= drop_d;
      buf_q  <= buf_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a FIFO model and
// an in-order scoreboard on the stream side.
module tb_fifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       r_rst;
  logic       en;
  logic       flush;
  logic       fifo_rd_empty;
  logic [7:0] fifo_d_output;
  logic       fifo_rd_inc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [3:0] rd_count;
  logic [3:0] drop_count;

  logic [7:0] mem [0:255];
  int         wp = 0;
  int         rp = 0;
  int         dp = 0;
  int         inflight = 0;
  logic       stall = 1'b0;
  int         total = 0;
  int         bad = 0;

  fifo_rd_stream #(.D_SIZE(8), .CNT_W(4)) dut (
    .rd_clk        (rd_clk),
    .r_rst         (r_rst),
    .en            (en),
    .flush         (flush),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_d_output (fifo_d_output),
    .fifo_rd_inc   (fifo_rd_inc),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .rd_count      (rd_count),
    .drop_count    (drop_count)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_rd_empty = (wp == rp) || stall;

  always @(posedge rd_clk) begin
    if (fifo_rd_inc) begin
      fifo_d_output <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp[7:0]] = v;
    wp++;
  endtask

  // Scoreboard and occupancy bound, evaluated on values that the next
  // rising edge will sample.
  always @(negedge rd_clk) begin
    if (!r_rst) begin
      inflight = 0;
      dp = rp;
    end else begin
      if (fifo_rd_inc && inflight == 3) begin
        chk("pop_overrun", 32'(fifo_rd_inc), 32'd0);
      end
      if (flush) begin
        dp = dp + inflight;
        inflight = 0;
      end else begin
        if (m_valid && m_ready) begin
          chk("sb_data", 32'(m_data), 32'(mem[dp[7:0]]));
          dp++;
          inflight--;
        end
        if (fifo_rd_inc) inflight++;
      end
    end
  end

  initial begin
    int r0;
    r_rst   = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    step(2);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_rdcnt", 32'(rd_count), 32'd0);
    r_rst = 1'b1;
    step(1);

    // Reset mid-stream with two words buffered
    en = 1'b1;
    push(8'hA1);
    push(8'hA2);
    step(5);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_data", 32'(m_data), 32'hA1);
    r_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_rdcnt", 32'(rd_count), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_inc", 32'(fifo_rd_inc), 32'd0);
    step(2);
    r_rst = 1'b1;
    step(1);

    // Full-throughput burst of four words
    m_ready = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    #1;
    for (int i = 0; i < 7; i++) begin
      chk("burst_inc", 32'(fifo_rd_inc), 32'(i < 4));
      chk("burst_valid", 32'(m_valid), 32'(i >= 2 && i < 6));
      if (i >= 2 && i < 6) chk("burst_data", 32'(m_data), 32'(8'h11 * (i - 1)));
      step(1);
    end
    chk("burst_rdcnt", 32'(rd_count), 32'd4);

    // Backpressure: three pops then hold
    m_ready = 1'b0;
    r0 = rp;
    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    step(6);
    chk("bp_pops", 32'(rp - r0), 32'd3);
    chk("bp_inc", 32'(fifo_rd_inc), 32'd0);
    chk("bp_empty", 32'(fifo_rd_empty), 32'd0);
    chk("bp_hold", 32'(m_data), 32'h50);
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_data", 32'(m_data), 32'(8'h50 + i));
      step(1);
    end
    chk("bp_rdcnt", 32'(rd_count), 32'd12);

    // Toggling ready and random empty over 50 words
    for (int i = 0; i < 50; i++) push(8'($urandom));
    for (int c = 0; c < 2000 && dp < wp; c++) begin
      m_ready = ~m_ready;
      stall = 1'($urandom_range(0, 1));
      step(1);
    end
    stall = 1'b0;
    m_ready = 1'b0;
    chk("rand_done", 32'(dp), 32'(wp));
    chk("rand_rdcnt", 32'(rd_count), 32'd14);
    step(2);

    // Flush with occ=2 and one pop in flight
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    step(3);
    flush = 1'b1;
    #1;
    chk("fl_inc", 32'(fifo_rd_inc), 32'd0);
    step(1);
    chk("fl_valid", 32'(m_valid), 32'd0);
    chk("fl_drop", 32'(drop_count), 32'd3);
    chk("fl_inc_gate", 32'(fifo_rd_inc), 32'd0);
    flush = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("fl_resume_inc", 32'(fifo_rd_inc), 32'd1);
    step(2);
    chk("fl_resume_d3", 32'(m_data), 32'hC3);
    step(1);
    chk("fl_resume_d4", 32'(m_data), 32'hC4);
    step(2);
    chk("fl_rdcnt", 32'(rd_count), 32'd0);

    // Counter wrap at CNT_W=4
    for (int i = 0; i < 17; i++) push(8'(i));
    for (int c = 0; c < 200 && dp < wp; c++) step(1);
    step(1);
    chk("wrap_rdcnt", 32'(rd_count), 32'd1);

    // en deassert with a pop in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hE0 + i));
    #1;
    step(2);
    en = 1'b0;
    #1;
    chk("en_inc0", 32'(fifo_rd_inc), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("en_inc", 32'(fifo_rd_inc), 32'd0);
    end
    chk("en_valid", 32'(m_valid), 32'd0);
    chk("en_empty", 32'(fifo_rd_empty), 32'd0);
    chk("en_rdcnt", 32'(rd_count), 32'd3);
    en = 1'b1;
    for (int c = 0; c < 200 && dp < wp; c++) step(1);
    step(1);
    chk("en_done", 32'(dp), 32'(wp));
    chk("en_rdcnt2", 32'(rd_count), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
